syn_adc_cap: RTL and testbench
==============================

SYN_ADC_CAP -- requirements
Module: syn_adc_cap

Interface
REQ-001 Parameter: SYNC_STAGES, 2, number of flops in each input synchronizer (min 2).
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 adc_en  in  1  capture enable; low forces IDLE.
REQ-005 bps  in  bps_t  bits per sample (BPS_16/BPS_32), latched per frame.
REQ-006 bclk  in  1  codec bit clock, asynchronous to clk, at most clk/4.
REQ-007 adc_lrc  in  1  codec L/R clock; 0=left, 1=right (I2S).
REQ-008 adc_dat  in  1  codec serial data, MSB first.
REQ-009 pcm_data  out  pcm_data_t  captured stereo sample.
REQ-010 pcm_valid  out  1  pcm_data holds an unconsumed sample.
REQ-011 pcm_ready  in  1  downstream accepts; transfer on pcm_valid&pcm_ready.
REQ-012 ovrflw  out  1  sticky: completed frame dropped because output full.
REQ-013 frm_err  out  1  sticky: lrc toggled before a channel word completed.
REQ-014 err_clr  in  1  single-cycle pulse clearing ovrflw and frm_err.

Function
REQ-015 bclk, adc_lrc, adc_dat shall each pass through SYNC_STAGES flops; a bclk rising edge is detected as synced-current=1, synced-previous=0.
REQ-016 All capture actions shall occur only in the clk cycle of a detected bclk rising edge, using synchronized lrc/dat.
REQ-017 FSM states: IDLE, SYNC, SKIP_L, LEFT, SKIP_R, RIGHT.
REQ-018 IDLE -> SYNC when adc_en=1; any state -> IDLE when adc_en=0, partial frame discarded.
REQ-019 SYNC -> SKIP_L on lrc 1->0 edge; bps latched into a frame register at this transition.
REQ-020 SKIP_L/SKIP_R consume exactly one bclk edge (I2S one-bit delay), then -> LEFT/RIGHT with bit counter=0.
REQ-021 LEFT/RIGHT shift adc_dat into a 32-bit shift register MSB first; counter increments per edge; word complete at count 16 (BPS_16) or 32 (BPS_32).
REQ-022 After word completion, remaining bits in the slot shall be ignored until the next lrc edge.
REQ-023 LEFT complete and lrc 0->1 -> SKIP_R; RIGHT complete and lrc 1->0 -> SKIP_L (next frame, bps re-latched).
REQ-024 lrc edge in LEFT/RIGHT before word complete: set frm_err, discard frame, -> SYNC.
REQ-025 BPS_16 words shall be sign-extended to 32 bits in lchnnl/rchnnl; BPS_32 words stored unchanged.
REQ-026 Right word completion shall load {left,right} into pcm_data and assert pcm_valid on the next clk edge (1-cycle latency from the completing bclk edge detect).
REQ-027 If pcm_valid=1 and pcm_ready=0 at completion, the new frame is dropped, pcm_data unchanged, ovrflw set.
REQ-028 If pcm_ready=1 in the same cycle as a completion, the old sample transfers and the new one loads; pcm_valid stays 1, ovrflw not set.
REQ-029 pcm_data shall stay stable while pcm_valid=1 and not transferred; pcm_valid clears the cycle after a transfer with no simultaneous load.
REQ-030 err_clr concurrent with a new error event: set wins.
REQ-031 adc_en deassertion shall not clear pcm_valid/pcm_data; the held sample remains deliverable.

Reset
REQ-032 On rst_n=0: FSM=IDLE, counters/shift register=0, synchronizers=0, pcm_data=0, pcm_valid=0, ovrflw=0, frm_err=0.
REQ-033 Reset mid-frame discards all partial data; after release capture restarts via SYNC, never mid-word.

Structure
REQ-034 pcm_data_t and bps_t from syn_audio_pkg; the FSM state enum shall be added to syn_audio_pkg.
REQ-035 Sub-module syn_sync_edge (SYNC_STAGES synchronizer plus rise-edge detect) instantiated for bclk; lrc/dat use plain synchronizers.

Verification
REQ-036 BPS_16, left=0x8001, right=0x1234, pcm_ready=1 -> one beat pcm_data={0xFFFF8001,0x00001234}, ovrflw=0.
REQ-037 BPS_32, left=0xDEADBEEF, right=0x01234567 -> pcm_data={0xDEADBEEF,0x01234567}, valid 1 cycle after last right-bit edge.
REQ-038 pcm_ready=0, three frames -> first frame held, ovrflw=1 after frame 2; err_clr -> ovrflw=0.
REQ-039 lrc toggles after 10 left bits (BPS_16) -> frm_err=1, no pcm_valid; next clean frame captured correctly.
REQ-040 rst_n or adc_en low mid-right word -> no pcm_valid for that frame; subsequent frame captured correctly.

Source files
------------

// File: rtl/syn_audio_pkg.sv
// -----------------------------------------------------------------------------
// syn_audio_pkg
// Shared audio types for the capture path:
//   bps_t       - bits per sample selector (16 or 32 bit words)
//   pcm_data_t  - captured stereo sample, left channel in the upper half
//   fsm_state_t - states of the I2S capture FSM in syn_adc_cap
// Helpers:
//   word_len()  - number of bits in a channel word for a given bps_t
//   fmt_word()  - sign-extends 16-bit words to 32 bits, passes 32-bit words
// -----------------------------------------------------------------------------
package syn_audio_pkg;

    typedef enum logic {
        BPS_16 = 1'b0,
        BPS_32 = 1'b1
    } bps_t;

    typedef struct packed {
        logic [31:0] left;
        logic [31:0] right;
    } pcm_data_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        SKIP_L = 3'd2,
        LEFT   = 3'd3,
        SKIP_R = 3'd4,
        RIGHT  = 3'd5
    } fsm_state_t;

    localparam logic [5:0] WORD_LEN_16 = 6'd16;
    localparam logic [5:0] WORD_LEN_32 = 6'd32;

    function automatic logic [5:0] word_len(input bps_t b);
        return (b == BPS_32) ? WORD_LEN_32 : WORD_LEN_16;
    endfunction

    function automatic logic [31:0] fmt_word(input bps_t b, input logic [31:0] w);
        return (b == BPS_32) ? w : {{16{w[15]}}, w[15:0]};
    endfunction

endpackage

// File: rtl/syn_sync_edge.sv
// -----------------------------------------------------------------------------
// syn_sync_edge
// Multi-flop synchronizer for an asynchronous single-bit input followed by a
// rising-edge detector on the synchronized value.
// Ports:
//   clk, rst_n - system clock, asynchronous active-low reset
//   din        - asynchronous input
//   rise       - one clk cycle high when the synchronized value goes 0 -> 1
// -----------------------------------------------------------------------------
module syn_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] sync_sr;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_sr <= '0;
            prev    <= 1'b0;
        end else begin
            sync_sr <= {sync_sr[STAGES-2:0], din};
            prev    <= sync_sr[STAGES-1];
        end
    end

    assign rise = sync_sr[STAGES-1] & ~prev;

endmodule

// File: rtl/syn_adc_cap.sv
// -----------------------------------------------------------------------------
// syn_adc_cap
// I2S codec capture. bclk/lrc/dat are synchronized into the clk domain; every
// capture action happens in the clk cycle where a bclk rising edge is seen.
// A frame is a left word (lrc=0) followed by a right word (lrc=1); after the
// right word completes the stereo sample is offered on pcm_data/pcm_valid.
//
// Ports:
//   clk, rst_n        - system clock, asynchronous active-low reset
//   adc_en            - capture enable, low returns the FSM to IDLE
//   bps               - word size, sampled at each left-frame start
//   bclk/adc_lrc/adc_dat - codec serial interface (asynchronous)
//   pcm_data/pcm_valid/pcm_ready - output handshake
//   ovrflw            - sticky, a finished frame was dropped (output full)
//   frm_err           - sticky, lrc toggled before a channel word completed
//   err_clr           - pulse clearing ovrflw and frm_err (a new error wins)
//   dbg_state         - current FSM state, for observation only
//
// Output handshake: pcm_data is valid while pcm_valid=1 and is held stable
// until a cycle with pcm_valid=1 and pcm_ready=1, which is the transfer.
// A new frame may load in the transfer cycle itself; if the output is full
// and not being transferred, the new frame is dropped and ovrflw is set.
//
// Frame timing: the bclk edge on which lrc is first seen at its new level
// moves the FSM into SKIP_L/SKIP_R; the following edge is the one-bit delay
// slot and is skipped; the word bits start on the edge after that.
// -----------------------------------------------------------------------------
module syn_adc_cap
    import syn_audio_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adc_en,
    input  bps_t       bps,
    input  logic       bclk,
    input  logic       adc_lrc,
    input  logic       adc_dat,
    output pcm_data_t  pcm_data,
    output logic       pcm_valid,
    input  logic       pcm_ready,
    output logic       ovrflw,
    output logic       frm_err,
    input  logic       err_clr,
    output fsm_state_t dbg_state
);

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic                   bclk_rise;
    logic [SYNC_STAGES-1:0] lrc_sr;
    logic [SYNC_STAGES-1:0] dat_sr;
    logic                   lrc_s;
    logic                   dat_s;

    syn_sync_edge #(
        .STAGES(SYNC_STAGES)
    ) u_bclk_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bclk),
        .rise (bclk_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lrc_sr <= '0;
            dat_sr <= '0;
        end else begin
            lrc_sr <= {lrc_sr[SYNC_STAGES-2:0], adc_lrc};
            dat_sr <= {dat_sr[SYNC_STAGES-2:0], adc_dat};
        end
    end

    assign lrc_s = lrc_sr[SYNC_STAGES-1];
    assign dat_s = dat_sr[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    fsm_state_t  state;
    bps_t        frame_bps;
    logic        lrc_last;    // lrc as seen on the previous bclk edge
    logic [5:0]  cnt;
    logic [30:0] shreg;       // bits so far; the incoming bit completes 32
    logic [31:0] lchnnl;

    logic        lrc_edge;
    logic [31:0] shift_nxt;
    logic [5:0]  cnt_nxt;
    logic [5:0]  len;
    logic        word_done;
    logic        in_word;
    logic        word_end;
    logic        right_done;
    logic        frm_evt;
    logic [31:0] rchnnl;

    assign lrc_edge   = lrc_s ^ lrc_last;
    assign shift_nxt  = {shreg, dat_s};
    assign cnt_nxt    = cnt + 6'd1;
    assign len        = word_len(frame_bps);
    assign word_done  = (cnt == len);
    assign in_word    = (state == LEFT) || (state == RIGHT);
    // The edge that delivers the last bit of a word (no lrc change on it).
    assign word_end   = adc_en && bclk_rise && in_word && !lrc_edge
                        && !word_done && (cnt_nxt == len);
    assign right_done = word_end && (state == RIGHT);
    assign frm_evt    = adc_en && bclk_rise && in_word && lrc_edge && !word_done;
    assign rchnnl     = fmt_word(frame_bps, shift_nxt);
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            frame_bps <= BPS_16;
            lrc_last  <= 1'b0;
            cnt       <= '0;
            shreg     <= '0;
            lchnnl    <= '0;
        end else begin
            if (bclk_rise) begin
                lrc_last <= lrc_s;
            end
            if (!adc_en) begin
                state <= IDLE;
                cnt   <= '0;
                shreg <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= SYNC;
                    end
                    SYNC: begin
                        if (bclk_rise && lrc_last && !lrc_s) begin
                            state     <= SKIP_L;
                            frame_bps <= bps;
                        end
                    end
                    SKIP_L, SKIP_R: begin
                        if (bclk_rise) begin
                            state <= (state == SKIP_L) ? LEFT : RIGHT;
                            cnt   <= '0;
                            shreg <= '0;
                        end
                    end
                    LEFT, RIGHT: begin
                        if (bclk_rise) begin
                            if (lrc_edge) begin
                                // Inside a slot lrc can only move to the
                                // opposite channel, so any edge ends the slot.
                                if (!word_done) begin
                                    state <= SYNC;
                                end else if (state == LEFT) begin
                                    state <= SKIP_R;
                                end else begin
                                    state     <= SKIP_L;
                                    frame_bps <= bps;
                                end
                            end else if (!word_done) begin
                                shreg <= shift_nxt[30:0];
                                cnt   <= cnt_nxt;
                                if (word_end && state == LEFT) begin
                                    lchnnl <= fmt_word(frame_bps, shift_nxt);
                                end
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register and sticky error flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcm_data  <= '0;
            pcm_valid <= 1'b0;
            ovrflw    <= 1'b0;
            frm_err   <= 1'b0;
        end else begin
            if (right_done && (!pcm_valid || pcm_ready)) begin
                pcm_data  <= '{left: lchnnl, right: rchnnl};
                pcm_valid <= 1'b1;
            end else if (pcm_valid && pcm_ready) begin
                pcm_valid <= 1'b0;
            end

            if (right_done && pcm_valid && !pcm_ready) begin
                ovrflw <= 1'b1;
            end else if (err_clr) begin
                ovrflw <= 1'b0;
            end

            if (frm_evt) begin
                frm_err <= 1'b1;
            end else if (err_clr) begin
                frm_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_syn_adc_cap.sv
// -----------------------------------------------------------------------------
// tb_syn_adc_cap
// Drives an I2S codec stream into syn_adc_cap and checks captured samples
// against a frame-level model: each clean frame yields {fmt(left), fmt(right)}
// where 16-bit words are sign-extended; a full output drops later frames.
// Codec timing used: per slot, edge 0 carries the first new lrc level, edge 1
// is the one-bit delay, edges 2.. carry the word MSB first, rest is filler.
// -----------------------------------------------------------------------------
module tb_syn_adc_cap;
    import syn_audio_pkg::*;

    localparam int SYNC_STAGES = 2;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic       adc_en;
    bps_t       bps;
    logic       bclk;
    logic       adc_lrc;
    logic       adc_dat;
    pcm_data_t  pcm_data;
    logic       pcm_valid;
    logic       pcm_ready;
    logic       ovrflw;
    logic       frm_err;
    logic       err_clr;
    fsm_state_t dbg_state;

    always #5 clk = ~clk;

    syn_adc_cap #(
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .adc_en   (adc_en),
        .bps      (bps),
        .bclk     (bclk),
        .adc_lrc  (adc_lrc),
        .adc_dat  (adc_dat),
        .pcm_data (pcm_data),
        .pcm_valid(pcm_valid),
        .pcm_ready(pcm_ready),
        .ovrflw   (ovrflw),
        .frm_err  (frm_err),
        .err_clr  (err_clr),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    int n_cmp = 0;
    int n_err = 0;

    always @(negedge clk) begin
        if (rst_n && pcm_valid && pcm_ready) obs_q.push_back(pcm_data);
    end

    // Reference formatting: a 16-bit word is a signed sample widened to 32.
    function automatic logic [31:0] ref_word(input bps_t b, input logic [31:0] w);
        shortint s;
        int      v;
        if (b == BPS_32) return w;
        s = shortint'(w[15:0]);
        v = int'(s);
        return 32'(v);
    endfunction

    function automatic int nbits_of(input bps_t b);
        return (b == BPS_32) ? 32 : 16;
    endfunction

    // ---------------- drivers ----------------
    task automatic send_bit(input logic l, input logic d);
        @(posedge clk);
        #3;
        bclk    = 1'b0;
        adc_lrc = l;
        adc_dat = d;
        #40;
        bclk = 1'b1;
        #36;
    endtask

    task automatic send_slot(input logic l, input logic [31:0] w, input int nbits,
                             input int slot_len);
        for (int i = 0; i < slot_len; i++) begin
            logic d;
            if (i >= 2 && i < nbits + 2) d = w[nbits+1-i];
            else d = 1'($urandom_range(0, 1));
            send_bit(l, d);
        end
    endtask

    task automatic send_frame(input bps_t b, input logic [31:0] l, input logic [31:0] r);
        int nb;
        bps = b;
        nb  = nbits_of(b);
        send_slot(1'b0, l, nb, nb + 2 + $urandom_range(0, 5));
        send_slot(1'b1, r, nb, nb + 2 + $urandom_range(0, 5));
    endtask

    task automatic preamble(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1, 1'($urandom_range(0, 1)));
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        pcm_ready = v;
    endtask

    task automatic pulse_err_clr();
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; adc_en = 1'b0; bps = BPS_16; bclk = 1'b0;
        adc_lrc = 1'b0; adc_dat = 1'b0; pcm_ready = 1'b1; err_clr = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (pcm_valid !== 1'b0 || pcm_data !== 64'd0 || ovrflw !== 1'b0 || frm_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%b data=%h ovrflw=%b frm_err=%b, required 0/0/0/0",
                     pcm_valid, pcm_data, ovrflw, frm_err);
        end
        n_cmp++;
        if (dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        adc_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (dbg_state !== SYNC) begin
            n_err++;
            $display("FAIL enable_to_sync: got %0d required %0d", dbg_state, SYNC);
        end
        preamble(4);
    endtask

    task automatic test_bps16_fixed();
        obs_q.delete();
        send_frame(BPS_16, 32'h0000_8001, 32'h0000_1234);
        settle();
        n_cmp++;
        if (obs_q.size() != 1) begin
            n_err++;
            $display("FAIL bps16_beats: got %0d required 1", obs_q.size());
        end else begin
            n_cmp++;
            if (obs_q[0] !== 64'hFFFF8001_00001234) begin
                n_err++;
                $display("FAIL bps16_data: got %h required %h", obs_q[0], 64'hFFFF8001_00001234);
            end
        end
        n_cmp++;
        if (ovrflw !== 1'b0) begin
            n_err++;
            $display("FAIL bps16_ovrflw: got %b required 0", ovrflw);
        end
    endtask

    task automatic test_latency_bps32();
        logic [31:0] l = 32'hDEADBEEF;
        logic [31:0] r = 32'h01234567;
        obs_q.delete();
        bps = BPS_32;
        send_slot(1'b0, l, 32, 34);
        // right slot: detect, delay, 31 bits, then the last bit by hand
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        for (int i = 31; i >= 1; i--) send_bit(1'b1, r[i]);
        @(posedge clk);
        #3;
        bclk = 1'b0; adc_lrc = 1'b1; adc_dat = r[0];
        #40;
        bclk = 1'b1;
        repeat (SYNC_STAGES) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (pcm_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bps32_early_valid: got %b required 0", pcm_valid);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (pcm_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bps32_latency: got %b required 1", pcm_valid);
        end
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'($urandom_range(0, 1)));
        settle();
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0] !== 64'hDEADBEEF_01234567) begin
            n_err++;
            $display("FAIL bps32_data: beats=%0d first=%h required 1 beat of %h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'd0, 64'hDEADBEEF_01234567);
        end
    endtask

    task automatic test_random_frames();
        obs_q.delete();
        exp_q.delete();
        for (int f = 0; f < 6; f++) begin
            bps_t        b = bps_t'($urandom_range(0, 1));
            logic [31:0] l = $urandom;
            logic [31:0] r = $urandom;
            exp_q.push_back({ref_word(b, l), ref_word(b, r)});
            send_frame(b, l, r);
        end
        settle();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL random_beats: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL random_data[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] held = '0;
        logic        full = 1'b0;
        logic        m_ovf = 1'b0;
        obs_q.delete();
        set_ready(1'b0);
        for (int f = 0; f < 3; f++) begin
            bps_t        b = bps_t'($urandom_range(0, 1));
            logic [31:0] l = $urandom;
            logic [31:0] r = $urandom;
            if (!full) begin
                held = {ref_word(b, l), ref_word(b, r)};
                full = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
            send_frame(b, l, r);
            settle();
            n_cmp++;
            if (pcm_valid !== 1'b1 || pcm_data !== held || ovrflw !== m_ovf) begin
                n_err++;
                $display("FAIL backpressure_frame%0d: valid=%b data=%h ovrflw=%b required 1/%h/%b",
                         f, pcm_valid, pcm_data, ovrflw, held, m_ovf);
            end
        end
        pulse_err_clr();
        @(negedge clk);
        n_cmp++;
        if (ovrflw !== 1'b0 || pcm_valid !== 1'b1) begin
            n_err++;
            $display("FAIL ovrflw_clear: ovrflw=%b valid=%b required 0/1", ovrflw, pcm_valid);
        end
        set_ready(1'b1);
        settle();
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0] !== held || pcm_valid !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_drain: beats=%0d first=%h valid=%b required 1 beat of %h, valid 0",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'd0, pcm_valid, held);
        end
    endtask

    task automatic test_frame_error();
        logic [31:0] l = $urandom;
        logic [31:0] r = $urandom;
        obs_q.delete();
        bps = BPS_16;
        send_slot(1'b0, 32'($urandom), 16, 12);   // only 10 left bits fit
        send_slot(1'b1, 32'($urandom), 16, 18);
        settle();
        n_cmp++;
        if (frm_err !== 1'b1 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL frame_error: frm_err=%b beats=%0d required 1/0", frm_err, obs_q.size());
        end
        send_frame(BPS_16, l, r);
        settle();
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0] !== {ref_word(BPS_16, l), ref_word(BPS_16, r)}) begin
            n_err++;
            $display("FAIL frame_error_recover: beats=%0d first=%h required %h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'd0,
                     {ref_word(BPS_16, l), ref_word(BPS_16, r)});
        end
        pulse_err_clr();
        @(negedge clk);
        n_cmp++;
        if (frm_err !== 1'b0) begin
            n_err++;
            $display("FAIL frm_err_clear: got %b required 0", frm_err);
        end
    endtask

    // use_reset=0: adc_en drop, use_reset=1: rst_n pulse, both mid right word
    task automatic test_abort(input logic use_reset);
        bps_t        b  = bps_t'($urandom_range(0, 1));
        int          nb = nbits_of(b);
        logic [31:0] l  = $urandom;
        logic [31:0] r  = $urandom;
        obs_q.delete();
        bps = b;
        send_slot(1'b0, 32'($urandom), nb, nb + 2);
        send_slot(1'b1, 32'($urandom), nb, 8);
        @(posedge clk);
        #1;
        if (use_reset) rst_n = 1'b0;
        else adc_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL abort%0d_idle: got %0d required %0d", use_reset, dbg_state, IDLE);
        end
        #1;
        rst_n  = 1'b1;
        adc_en = 1'b1;
        preamble(nb);
        settle();
        n_cmp++;
        if (obs_q.size() != 0 || pcm_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort%0d_no_beat: beats=%0d valid=%b required 0/0",
                     use_reset, obs_q.size(), pcm_valid);
        end
        send_frame(b, l, r);
        settle();
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0] !== {ref_word(b, l), ref_word(b, r)}) begin
            n_err++;
            $display("FAIL abort%0d_recover: beats=%0d first=%h required %h", use_reset,
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'd0,
                     {ref_word(b, l), ref_word(b, r)});
        end
    endtask

    task automatic test_enable_hold();
        bps_t        b = bps_t'($urandom_range(0, 1));
        logic [31:0] l = $urandom;
        logic [31:0] r = $urandom;
        logic [63:0] e;
        e = {ref_word(b, l), ref_word(b, r)};
        obs_q.delete();
        set_ready(1'b0);
        send_frame(b, l, r);
        @(posedge clk);
        #1;
        adc_en = 1'b0;
        settle();
        n_cmp++;
        if (pcm_valid !== 1'b1 || pcm_data !== e || dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL enable_hold: valid=%b data=%h state=%0d required 1/%h/%0d",
                     pcm_valid, pcm_data, dbg_state, e, IDLE);
        end
        set_ready(1'b1);
        settle();
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0] !== e) begin
            n_err++;
            $display("FAIL enable_hold_drain: beats=%0d first=%h required %h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'd0, e);
        end
        #1;
        adc_en = 1'b1;
        preamble(3);
    endtask

    // ---------------- sequence ----------------
    initial begin
        test_reset();
        test_bps16_fixed();
        test_latency_bps32();
        test_random_frames();
        test_backpressure();
        test_frame_error();
        test_abort(1'b0);
        test_abort(1'b1);
        test_enable_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

endmodule
